// File: rtl/iter_comparator_if.sv
// Request/result handshake bundle for iter_comparator.
// master drives requests and result-ready; slave is the comparator.
interface iter_comparator_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] rs1d;
  logic [WIDTH-1:0] rs2d;
  logic             s;
  logic             out_valid;
  logic             out_ready;
  logic             eq;
  logic             lt;

  modport master (
    output in_valid, rs1d, rs2d, s, out_ready,
    input  in_ready, out_valid, eq, lt
  );

  modport slave (
    input  in_valid, rs1d, rs2d, s, out_ready,
    output in_ready, out_valid, eq, lt
  );
endinterface

// File: rtl/iter_comparator.sv
// Chunk-serial eq/lt comparator, MSB chunk first, signed or unsigned.
// Ports: clk, rst_n (async low), bus (slave: req/result valid-ready).
module iter_comparator #(
  parameter int WIDTH      = 32,
  parameter int CHUNK      = 8,
  parameter int EARLY_EXIT = 1
) (
  input logic         clk,
  input logic         rst_n,
  iter_comparator_if.slave bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int KW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);
  localparam logic [WIDTH-1:0] MSB = WIDTH'(1) << (WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [KW-1:0]    k;
  logic             diff_seen;
  logic             out_valid_q;
  logic             eq_q;
  logic             lt_q;

  logic [CHUNK-1:0] a_c;
  logic [CHUNK-1:0] b_c;
  logic [WIDTH-1:0] flip;
  logic             accept;
  logic             differ;
  logic             hit;
  logic             last;
  logic             stop;

  assign bus.in_ready = (state == IDLE) ||
                        (state == DONE && bus.out_ready);
  assign bus.out_valid = out_valid_q;
  assign bus.eq = eq_q;
  assign bus.lt = lt_q;

  assign accept = bus.in_valid && bus.in_ready;
  // Flipping the sign bit maps two's complement order onto unsigned order.
  assign flip = bus.s ? MSB : '0;

  assign a_c = a_q[WIDTH-1-int'(k)*CHUNK -: CHUNK];
  assign b_c = b_q[WIDTH-1-int'(k)*CHUNK -: CHUNK];

  assign differ = (a_c != b_c);
  assign hit = !diff_seen && differ;
  assign last = (k == K_LAST);
  assign stop = last || ((EARLY_EXIT != 0) && hit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      k           <= '0;
      diff_seen   <= 1'b0;
      out_valid_q <= 1'b0;
      eq_q        <= 1'b0;
      lt_q        <= 1'b0;
    end else begin
      // Accept from IDLE or from DONE (back-to-back, no IDLE bubble).
      if (accept) begin
        a_q       <= bus.rs1d ^ flip;
        b_q       <= bus.rs2d ^ flip;
        k         <= '0;
        diff_seen <= 1'b0;
        state     <= RUN;
      end
      unique case (1'b1)
        (state == IDLE): begin
        end
        (state == RUN): begin
          if (hit) begin
            lt_q      <= (a_c < b_c);
            eq_q      <= 1'b0;
            diff_seen <= 1'b1;
          end
          if (stop) begin
            state       <= DONE;
            out_valid_q <= 1'b1;
            if (last && !diff_seen && !differ) begin
              eq_q <= 1'b1;
              lt_q <= 1'b0;
            end
          end else begin
            k <= k + 1'b1;
          end
        end
        (state == DONE): begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            if (!bus.in_valid) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_iter_comparator.sv
// Directed bench for iter_comparator, early-exit and constant-latency.
// Checks latency, eq/lt, backpressure, back-to-back and async reset.
module tb_iter_comparator;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        iv;
  logic        sg;
  logic        ordy;
  logic        sel;
  logic [31:0] a;
  logic [31:0] b;
  int          n_cmp = 0;
  int          n_err = 0;

  logic ov;
  logic rdy;
  logic eq;
  logic lt;

  always #5 clk = ~clk;

  iter_comparator_if #(.WIDTH(32)) bus_ee ();
  iter_comparator_if #(.WIDTH(32)) bus_ce ();

  assign bus_ee.in_valid  = iv && !sel;
  assign bus_ee.rs1d      = a;
  assign bus_ee.rs2d      = b;
  assign bus_ee.s         = sg;
  assign bus_ee.out_ready = ordy;

  assign bus_ce.in_valid  = iv && sel;
  assign bus_ce.rs1d      = a;
  assign bus_ce.rs2d      = b;
  assign bus_ce.s         = sg;
  assign bus_ce.out_ready = ordy;

  assign ov  = sel ? bus_ce.out_valid : bus_ee.out_valid;
  assign rdy = sel ? bus_ce.in_ready  : bus_ee.in_ready;
  assign eq  = sel ? bus_ce.eq        : bus_ee.eq;
  assign lt  = sel ? bus_ce.lt        : bus_ee.lt;

  iter_comparator #(
    .WIDTH(32), .CHUNK(8), .EARLY_EXIT(1)
  ) u_ee (
    .clk(clk), .rst_n(rst_n), .bus(bus_ee.slave)
  );

  iter_comparator #(
    .WIDTH(32), .CHUNK(8), .EARLY_EXIT(0)
  ) u_ce (
    .clk(clk), .rst_n(rst_n), .bus(bus_ce.slave)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one request, measure latency, check result, optionally consume.
  task automatic cmp_req(input string tag,
                         input logic [31:0] x,
                         input logic [31:0] y,
                         input logic sv,
                         input int lat_exp,
                         input logic eq_exp,
                         input logic lt_exp,
                         input logic consume);
    int lat;
    a = x; b = y; sg = sv; iv = 1'b1; ordy = 1'b0;
    check({tag, ".in_ready"}, 32'(rdy), 32'd1);
    @(posedge clk); #1;
    iv = 1'b0; a = ~x; b = ~y; sg = ~sv;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!ov && lat < 12);
    check({tag, ".lat"}, 32'(lat), 32'(lat_exp));
    check({tag, ".eq"}, 32'(eq), 32'(eq_exp));
    check({tag, ".lt"}, 32'(lt), 32'(lt_exp));
    if (consume) begin
      ordy = 1'b1;
      @(posedge clk); #1;
      ordy = 1'b0;
      check({tag, ".drain"}, 32'(ov), 32'd0);
    end
  endtask

  initial begin
    iv = 1'b0; sg = 1'b0; ordy = 1'b0; sel = 1'b0;
    a = '0; b = '0;

    #2;
    check("rst.ov_ee", 32'(bus_ee.out_valid), 32'd0);
    check("rst.ov_ce", 32'(bus_ce.out_valid), 32'd0);
    check("rst.rdy_ee", 32'(bus_ee.in_ready), 32'd1);
    check("rst.rdy_ce", 32'(bus_ce.in_ready), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("rel.rdy", 32'(rdy), 32'd1);
    check("rel.ov", 32'(ov), 32'd0);

    cmp_req("sgn_s1", 32'h8000_0000, 32'h0000_0001, 1'b1, 1, 1'b0, 1'b1, 1'b1);
    cmp_req("sgn_s0", 32'h8000_0000, 32'h0000_0001, 1'b0, 1, 1'b0, 1'b0, 1'b1);
    cmp_req("eq_s0", 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 4, 1'b1, 1'b0, 1'b1);
    cmp_req("eq_s1", 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 4, 1'b1, 1'b0, 1'b1);
    cmp_req("lsb", 32'h1234_5600, 32'h1234_5601, 1'b0, 4, 1'b0, 1'b1, 1'b1);
    cmp_req("neg_s1", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1, 1'b0, 1'b1, 1'b1);
    cmp_req("neg_s0", 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1, 1'b0, 1'b0, 1'b1);
    cmp_req("mid", 32'h0012_0000, 32'h0011_FFFF, 1'b0, 2, 1'b0, 1'b0, 1'b1);

    sel = 1'b1;
    cmp_req("ce.sgn", 32'h8000_0000, 32'h0000_0001, 1'b1, 4, 1'b0, 1'b1, 1'b1);
    cmp_req("ce.eq", 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 4, 1'b1, 1'b0, 1'b1);
    cmp_req("ce.keep", 32'h01FF_FFFF, 32'h0200_0000, 1'b0, 4, 1'b0, 1'b1, 1'b1);
    sel = 1'b0;

    cmp_req("bp", 32'h0000_0005, 32'h0000_0007, 1'b0, 4, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp.ov", 32'(ov), 32'd1);
      check("bp.eq", 32'(eq), 32'd0);
      check("bp.lt", 32'(lt), 32'd1);
      check("bp.rdy", 32'(rdy), 32'd0);
    end
    ordy = 1'b1; iv = 1'b1;
    a = 32'hFFFF_FFFF; b = 32'h0000_0000; sg = 1'b0;
    #1;
    check("b2b.rdy", 32'(rdy), 32'd1);
    @(posedge clk); #1;
    iv = 1'b0; ordy = 1'b0; a = '0;
    check("b2b.run", 32'(ov), 32'd0);
    check("b2b.busy", 32'(rdy), 32'd0);
    @(posedge clk); #1;
    check("b2b.ov", 32'(ov), 32'd1);
    check("b2b.eq", 32'(eq), 32'd0);
    check("b2b.lt", 32'(lt), 32'd0);
    ordy = 1'b1;
    @(posedge clk); #1;
    ordy = 1'b0;
    check("b2b.drain", 32'(ov), 32'd0);

    a = 32'hDEAD_BEEF; b = 32'hDEAD_BEEF; sg = 1'b0; iv = 1'b1;
    @(posedge clk); #1;
    iv = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("rmid.ov", 32'(ov), 32'd0);
    check("rmid.rdy", 32'(rdy), 32'd1);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("rmid.stale", 32'(ov), 32'd0);
    end
    cmp_req("fresh", 32'h0000_0005, 32'h0000_0007, 1'b0, 4, 1'b0, 1'b1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
